prog_run_checker: RTL and testbench
===================================

PROG_RUN_CHECKER -- requirements
Module: prog_run_checker

Interface
REQ-001 Parameters (name, default, meaning):
- DW, 64: processor data-memory output width.
- AW, 64: PC width.
- NPROG, 4: number of programs in the run table (1..16).
- WDW, 16: watchdog counter width.
- WD_LIMIT, 16'hFF: per-program cycle limit in RUN.
- RST_CYC, 1: cycles proc_resetl is held low (>=1).
- RESET_EACH, 0: 1 = reset processor before every program; 0 = reset only before program 0.

REQ-002 Ports (name, direction, width, meaning):
- CLK, in, 1: clock, rising edge.
- resetl, in, 1: reset, synchronous, active-low.
- start, in, 1: begin run; single-cycle pulse, sampled in IDLE only.
- currentpc, in, AW: processor PC.
- dmemout, in, DW: processor data-memory output.
- startpc_tbl, in, NPROG*AW: start PC per program; entry i at [i*AW +: AW].
- endpc_tbl, in, NPROG*AW: end PC per program, same packing.
- expect_tbl, in, NPROG*DW: expected dmemout per program, same packing.
- proc_resetl, out, 1: drives processor reset, active-low.
- startpc, out, AW: drives processor start PC; equals startpc_tbl entry prog_idx.
- prog_idx, out, $clog2(NPROG)+1: current program index.
- pass_cnt, out, $clog2(NPROG)+1: number of programs passed.
- fail_mask, out, NPROG: bit i set = program i failed.
- busy, out, 1: high in any state except IDLE and DONE.
- done, out, 1: high in DONE.
- all_pass, out, 1: done & (pass_cnt==NPROG).
- timeout, out, 1: sticky; watchdog expired in this run.

Function
REQ-003 FSM states: IDLE, PRST, RUN, SETTLE, CHECK, NEXT, DONE.
REQ-004 IDLE: start=1 -> clear pass_cnt, fail_mask, timeout and prog_idx; next state PRST.
REQ-005 PRST: proc_resetl=0 for exactly RST_CYC cycles, then RUN; watchdog cleared on entry.
REQ-006 RUN: currentpc >= endpc[prog_idx] (unsigned) -> SETTLE.
- Otherwise the watchdog increments.
- Watchdog == WD_LIMIT-1 while still below endpc -> set fail_mask[prog_idx] and timeout, then DONE (abort; remaining programs not run, not counted).
REQ-007 SETTLE: one cycle of wait so dmemout reflects the final load.
REQ-008 CHECK: dmemout is compared with expect[prog_idx] over all DW bits.
- Equal -> pass_cnt+1.
- Unequal -> fail_mask[prog_idx]=1.
- Next state NEXT.
REQ-009 NEXT:
- prog_idx==NPROG-1 -> DONE.
- Otherwise prog_idx+1 and watchdog cleared; then PRST if RESET_EACH=1, else RUN (processor keeps executing from its current PC).
REQ-010 DONE: outputs hold; start=1 -> same as REQ-004 (restart).
REQ-011 start outside IDLE/DONE is ignored.
REQ-012 proc_resetl=1 in every state except PRST.
REQ-013 Table inputs are sampled live; they must be stable while busy.
REQ-014 Latency, RESET_EACH=1: start to first proc_resetl=0 is 1 cycle; PC reaching endpc to pass_cnt/fail_mask update is 3 cycles (RUN->SETTLE->CHECK, register update at end of CHECK).
REQ-015 Watchdog saturates; it never wraps within one program.

Reset
REQ-016 resetl=0 at a CLK edge, from any state including mid-RUN, gives state IDLE.
- proc_resetl=1.
- prog_idx=0, pass_cnt=0, fail_mask=0, watchdog=0.
- busy=0, done=0, all_pass=0, timeout=0.
- startpc=startpc_tbl[0].
REQ-017 Module reset does not assert proc_resetl; the processor is reset only via PRST.

Verification
REQ-018 Benches must cover the following (NPROG=2, RESET_EACH=0, RST_CYC=1, endpc={0x70,0x34}, expect={0x123456789abcdef0,0xF}):
- Both programs correct: start, PC ramps by 4 per cycle, dmemout correct after each endpc -> pass_cnt=2, fail_mask=0, done=1, all_pass=1, proc_resetl low exactly 1 cycle.
- Program 1 dmemout=0x123456789abcdef1 -> pass_cnt=1, fail_mask=2'b10, all_pass=0, timeout=0.
- PC stuck at 0x10 -> after WD_LIMIT (0xFF) RUN cycles: timeout=1, fail_mask=2'b01, done=1, pass_cnt=0.
- RESET_EACH=1, RST_CYC=3 -> proc_resetl low for 3 cycles before each program (2 pulses); startpc switches to entry 1 before the second pulse.
- resetl=0 mid-RUN of program 1 -> all outputs at REQ-016 values the next cycle; a new start then reruns from program 0.
- start pulses while busy -> no effect on the run in progress.

Source files
------------

// File: rtl/prog_run_checker.sv
// rtl/prog_run_checker.sv - sequences a processor through a table of test programs and scores each result
module prog_run_checker #(
  parameter int             DW         = 64,
  parameter int             AW         = 64,
  parameter int             NPROG      = 4,
  parameter int             WDW        = 16,
  parameter logic [WDW-1:0] WD_LIMIT   = 16'hFF,
  parameter int             RST_CYC    = 1,
  parameter int             RESET_EACH = 0
) (
  input  logic                       CLK,
  input  logic                       resetl,
  input  logic                       start,
  input  logic [AW-1:0]              currentpc,
  input  logic [DW-1:0]              dmemout,
  input  logic [NPROG*AW-1:0]        startpc_tbl,
  input  logic [NPROG*AW-1:0]        endpc_tbl,
  input  logic [NPROG*DW-1:0]        expect_tbl,
  output logic                       proc_resetl,
  output logic [AW-1:0]              startpc,
  output logic [$clog2(NPROG):0]     prog_idx,
  output logic [$clog2(NPROG):0]     pass_cnt,
  output logic [NPROG-1:0]           fail_mask,
  output logic                       busy,
  output logic                       done,
  output logic                       all_pass,
  output logic                       timeout
);

  localparam int IW  = $clog2(NPROG) + 1;
  localparam int RCW = $clog2(RST_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRST   = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    prog_idx_q, prog_idx_d;
  logic [IW-1:0]    pass_cnt_q, pass_cnt_d;
  logic [NPROG-1:0] fail_mask_q, fail_mask_d;
  logic             timeout_q, timeout_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;

  logic [AW-1:0]    sel_startpc;
  logic [AW-1:0]    sel_endpc;
  logic [DW-1:0]    sel_expect;
  logic [NPROG-1:0] cur_bit;
  logic             is_last;

  // Pick the table entries for the current program; cur_bit is its one-hot fail_mask position
  always_comb begin
    sel_startpc = '0;
    sel_endpc   = '0;
    sel_expect  = '0;
    cur_bit     = '0;
    is_last     = (prog_idx_q == IW'(NPROG - 1));
    for (int i = 0; i < NPROG; i++) begin
      if (prog_idx_q == IW'(i)) begin
        sel_startpc = startpc_tbl[i*AW +: AW];
        sel_endpc   = endpc_tbl[i*AW +: AW];
        sel_expect  = expect_tbl[i*DW +: DW];
        cur_bit[i]  = 1'b1;
      end
    end
  end

  // State and scoreboard registers, cleared by the synchronous module reset
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q     <= S_IDLE;
      prog_idx_q  <= '0;
      pass_cnt_q  <= '0;
      fail_mask_q <= '0;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
      rst_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prog_idx_q  <= prog_idx_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_mask_q <= fail_mask_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  // Next-state logic: reset pulse, run with watchdog, settle, compare, advance
  always_comb begin
    state_d     = state_q;
    prog_idx_d  = prog_idx_q;
    pass_cnt_d  = pass_cnt_q;
    fail_mask_d = fail_mask_q;
    timeout_d   = timeout_q;
    wd_d        = wd_q;
    rst_cnt_d   = rst_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // start elsewhere is ignored because only these two states look at it
        if (start) begin
          pass_cnt_d  = '0;
          fail_mask_d = '0;
          timeout_d   = 1'b0;
          prog_idx_d  = '0;
          wd_d        = '0;
          rst_cnt_d   = '0;
          state_d     = S_PRST;
        end
      end
      S_PRST: begin
        if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
          rst_cnt_d = '0;
          state_d   = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (currentpc >= sel_endpc) begin
          state_d = S_SETTLE;
        end else if (wd_q == WD_LIMIT - 1'b1) begin
          // A hung program aborts the whole run; later programs stay unscored
          fail_mask_d = fail_mask_q | cur_bit;
          timeout_d   = 1'b1;
          state_d     = S_DONE;
        end else if (wd_q != {WDW{1'b1}}) begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_SETTLE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (dmemout == sel_expect) begin
          pass_cnt_d = pass_cnt_q + 1'b1;
        end else begin
          fail_mask_d = fail_mask_q | cur_bit;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (is_last) begin
          state_d = S_DONE;
        end else begin
          prog_idx_d = prog_idx_q + 1'b1;
          wd_d       = '0;
          rst_cnt_d  = '0;
          state_d    = (RESET_EACH != 0) ? S_PRST : S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign proc_resetl = (state_q != S_PRST);
  assign startpc     = sel_startpc;
  assign prog_idx    = prog_idx_q;
  assign pass_cnt    = pass_cnt_q;
  assign fail_mask   = fail_mask_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign all_pass    = done && (pass_cnt_q == IW'(NPROG));
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_prog_run_checker.sv
// tb/tb_prog_run_checker.sv - scoreboard bench for prog_run_checker with a simple processor model
module tb_prog_run_checker;

  logic           clk = 1'b0;
  logic           resetl = 1'b0;
  logic           start_a = 1'b0;
  logic           start_b = 1'b0;
  logic [63:0]    currentpc = '0;
  logic [63:0]    dmemout = '0;
  logic [127:0]   startpc_tbl = {64'h40, 64'h0};
  logic [127:0]   endpc_tbl   = {64'h70, 64'h34};
  logic [127:0]   expect_tbl  = {64'h123456789abcdef0, 64'hF};

  logic           prst_a, busy_a, done_a, all_pass_a, timeout_a;
  logic [63:0]    startpc_a;
  logic [1:0]     prog_idx_a, pass_cnt_a, fail_mask_a;
  logic           prst_b, busy_b, done_b, all_pass_b, timeout_b;
  logic [63:0]    startpc_b;
  logic [1:0]     prog_idx_b, pass_cnt_b, fail_mask_b;

  logic           use_b = 1'b0;
  logic           m_prst, m_busy, m_done, m_all_pass, m_timeout;
  logic [63:0]    m_startpc;
  logic [1:0]     m_prog_idx, m_pass_cnt, m_fail_mask;

  int             n_checks = 0;
  int             n_errors = 0;
  string          tag_q[$];
  logic [63:0]    exp_q[$];
  logic [63:0]    sp_q[$];

  always #5 clk = ~clk;

  prog_run_checker #(.DW(64), .AW(64), .NPROG(2), .RST_CYC(1), .RESET_EACH(0)) dut_a (
    .CLK(clk), .resetl(resetl), .start(start_a), .currentpc(currentpc), .dmemout(dmemout),
    .startpc_tbl(startpc_tbl), .endpc_tbl(endpc_tbl), .expect_tbl(expect_tbl),
    .proc_resetl(prst_a), .startpc(startpc_a), .prog_idx(prog_idx_a), .pass_cnt(pass_cnt_a),
    .fail_mask(fail_mask_a), .busy(busy_a), .done(done_a), .all_pass(all_pass_a), .timeout(timeout_a)
  );

  prog_run_checker #(.DW(64), .AW(64), .NPROG(2), .RST_CYC(3), .RESET_EACH(1)) dut_b (
    .CLK(clk), .resetl(resetl), .start(start_b), .currentpc(currentpc), .dmemout(dmemout),
    .startpc_tbl(startpc_tbl), .endpc_tbl(endpc_tbl), .expect_tbl(expect_tbl),
    .proc_resetl(prst_b), .startpc(startpc_b), .prog_idx(prog_idx_b), .pass_cnt(pass_cnt_b),
    .fail_mask(fail_mask_b), .busy(busy_b), .done(done_b), .all_pass(all_pass_b), .timeout(timeout_b)
  );

  assign m_prst      = use_b ? prst_b      : prst_a;
  assign m_busy      = use_b ? busy_b      : busy_a;
  assign m_done      = use_b ? done_b      : done_a;
  assign m_all_pass  = use_b ? all_pass_b  : all_pass_a;
  assign m_timeout   = use_b ? timeout_b   : timeout_a;
  assign m_startpc   = use_b ? startpc_b   : startpc_a;
  assign m_prog_idx  = use_b ? prog_idx_b  : prog_idx_a;
  assign m_pass_cnt  = use_b ? pass_cnt_b  : pass_cnt_a;
  assign m_fail_mask = use_b ? fail_mask_b : fail_mask_a;

  task automatic push(input string tag, input logic [63:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %0h expected nothing", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic push_reset_vals(input string p);
    push({p, "_proc_resetl"}, 64'd1);
    push({p, "_prog_idx"}, 64'd0);
    push({p, "_pass_cnt"}, 64'd0);
    push({p, "_fail_mask"}, 64'd0);
    push({p, "_busy"}, 64'd0);
    push({p, "_done"}, 64'd0);
    push({p, "_all_pass"}, 64'd0);
    push({p, "_timeout"}, 64'd0);
    push({p, "_startpc"}, 64'd0);
  endtask

  task automatic pop_reset_vals();
    pop_check(64'(prst_a));
    pop_check(64'(prog_idx_a));
    pop_check(64'(pass_cnt_a));
    pop_check(64'(fail_mask_a));
    pop_check(64'(busy_a));
    pop_check(64'(done_a));
    pop_check(64'(all_pass_a));
    pop_check(64'(timeout_a));
    pop_check(startpc_a);
  endtask

  // Processor model: PC held at startpc in reset, +4 per cycle otherwise; dmemout follows PC
  task automatic run(input bit b, input logic [63:0] d1val, input bit stuck, input bit spam,
                     input bit abort1, output int low, output int pulses, output int first_low,
                     output int lat, output int runcyc, output int expired);
    logic [63:0] pc_v;
    bit          prev;
    int          reach;
    pc_v = stuck ? 64'h10 : 64'h0;
    prev = 1'b0;
    low = 0; pulses = 0; first_low = -1; lat = -1; runcyc = 0; reach = -1; expired = 1;
    sp_q.delete();
    use_b = b;
    currentpc = pc_v;
    @(posedge clk); #1;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      if (m_done || (abort1 && m_prog_idx == 2'd1)) begin
        expired = 0;
        break;
      end
      if (spam && m_busy && (c % 5 == 2)) begin
        if (b) start_b = 1'b1; else start_a = 1'b1;
      end
      if (m_busy && m_prst) runcyc++;
      if (lat < 0 && reach >= 0 && m_pass_cnt != 2'd0) lat = c - reach;
      if (!m_prst) begin
        low++;
        if (first_low < 0) first_low = c;
        if (!prev) begin
          pulses++;
          sp_q.push_back(m_startpc);
        end
        if (!stuck) pc_v = m_startpc;
      end else if (!stuck) begin
        pc_v = pc_v + 64'd4;
      end
      prev = !m_prst;
      if (reach < 0 && m_busy && m_prst && pc_v >= 64'h34) reach = c;
      currentpc = pc_v;
      dmemout = (pc_v >= 64'h70) ? d1val : (pc_v >= 64'h34) ? 64'hF : 64'h0;
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low, pulses, first_low, lat, runcyc, expired;

    // Module reset: outputs at their idle values, processor reset not asserted
    resetl = 1'b0;
    push_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1;
    pop_reset_vals();
    resetl = 1'b1;

    // Both programs correct, with start pulses sprinkled in while busy
    push("s1_expired", 64'd0);
    push("s1_first_low", 64'd0);
    push("s1_low_cycles", 64'd1);
    push("s1_pulses", 64'd1);
    push("s1_latency", 64'd3);
    push("s1_pass_cnt", 64'd2);
    push("s1_fail_mask", 64'd0);
    push("s1_done", 64'd1);
    push("s1_all_pass", 64'd1);
    push("s1_timeout", 64'd0);
    run(1'b0, 64'h123456789abcdef0, 1'b0, 1'b1, 1'b0, low, pulses, first_low, lat, runcyc, expired);
    pop_check(64'(expired));
    pop_check(64'(first_low));
    pop_check(64'(low));
    pop_check(64'(pulses));
    pop_check(64'(lat));
    pop_check(64'(m_pass_cnt));
    pop_check(64'(m_fail_mask));
    pop_check(64'(m_done));
    pop_check(64'(m_all_pass));
    pop_check(64'(m_timeout));

    // Restart from DONE with program 1 producing a wrong value
    push("s2_expired", 64'd0);
    push("s2_pass_cnt", 64'd1);
    push("s2_fail_mask", 64'd2);
    push("s2_all_pass", 64'd0);
    push("s2_timeout", 64'd0);
    push("s2_done", 64'd1);
    run(1'b0, 64'h123456789abcdef1, 1'b0, 1'b0, 1'b0, low, pulses, first_low, lat, runcyc, expired);
    pop_check(64'(expired));
    pop_check(64'(m_pass_cnt));
    pop_check(64'(m_fail_mask));
    pop_check(64'(m_all_pass));
    pop_check(64'(m_timeout));
    pop_check(64'(m_done));

    // PC stuck below endpc: watchdog aborts after WD_LIMIT RUN cycles
    push("wd_expired", 64'd0);
    push("wd_timeout", 64'd1);
    push("wd_fail_mask", 64'd1);
    push("wd_done", 64'd1);
    push("wd_pass_cnt", 64'd0);
    push("wd_run_cycles", 64'd255);
    push("wd_all_pass", 64'd0);
    run(1'b0, 64'h123456789abcdef0, 1'b1, 1'b0, 1'b0, low, pulses, first_low, lat, runcyc, expired);
    pop_check(64'(expired));
    pop_check(64'(m_timeout));
    pop_check(64'(m_fail_mask));
    pop_check(64'(m_done));
    pop_check(64'(m_pass_cnt));
    pop_check(64'(runcyc));
    pop_check(64'(m_all_pass));

    // Module reset in the middle of program 1, then a clean rerun
    push("mid_reached_prog1", 64'd0);
    run(1'b0, 64'h123456789abcdef0, 1'b0, 1'b0, 1'b1, low, pulses, first_low, lat, runcyc, expired);
    pop_check(64'(expired));
    resetl = 1'b0;
    push_reset_vals("mid");
    @(posedge clk); #1;
    pop_reset_vals();
    resetl = 1'b1;
    push("rerun_expired", 64'd0);
    push("rerun_first_low", 64'd0);
    push("rerun_pass_cnt", 64'd2);
    push("rerun_all_pass", 64'd1);
    run(1'b0, 64'h123456789abcdef0, 1'b0, 1'b0, 1'b0, low, pulses, first_low, lat, runcyc, expired);
    pop_check(64'(expired));
    pop_check(64'(first_low));
    pop_check(64'(m_pass_cnt));
    pop_check(64'(m_all_pass));

    // Reset before every program, 3-cycle processor reset pulses
    push("re_expired", 64'd0);
    push("re_pulses", 64'd2);
    push("re_low_cycles", 64'd6);
    push("re_startpc0", 64'h0);
    push("re_startpc1", 64'h40);
    push("re_pass_cnt", 64'd2);
    push("re_fail_mask", 64'd0);
    push("re_all_pass", 64'd1);
    run(1'b1, 64'h123456789abcdef0, 1'b0, 1'b0, 1'b0, low, pulses, first_low, lat, runcyc, expired);
    pop_check(64'(expired));
    pop_check(64'(pulses));
    pop_check(64'(low));
    pop_check(sp_q.size() > 0 ? sp_q[0] : 64'hxxxxxxxxxxxxxxxx);
    pop_check(sp_q.size() > 1 ? sp_q[1] : 64'hxxxxxxxxxxxxxxxx);
    pop_check(64'(m_pass_cnt));
    pop_check(64'(m_fail_mask));
    pop_check(64'(m_all_pass));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
